// File: rtl/encode_pack_pkg.sv
// Shared definitions for the encoder sample packer: header layout, sample word
// layout and the state encodings of the capture and output FSMs.
package encode_pack_pkg;

    localparam logic [15:0] HDR_MAGIC     = 16'hEC0D;
    localparam int          HDR_MAGIC_LSB = 48;
    localparam int          HDR_SEQ_LSB   = 40;
    localparam int          HDR_OVF_BIT   = 32;
    localparam int          HDR_LEN_LSB   = 16;
    localparam int          SAMPLE_W      = 64;

    typedef enum logic [1:0] {
        CAP_IDLE      = 2'd0,
        CAP_WAIT_ZERO = 2'd1,
        CAP_RUN       = 2'd2
    } cap_state_t;

    typedef enum logic [1:0] {
        O_IDLE = 2'd0,
        O_HDR  = 2'd1,
        O_DATA = 2'd2
    } out_state_t;

    // Sample word: W position in the upper half, X position in the lower half.
    function automatic logic [SAMPLE_W-1:0] pack_sample(input logic [31:0] w,
                                                        input logic [31:0] x);
        return {w, x};
    endfunction

    function automatic logic [63:0] make_header(input logic [7:0]  seq,
                                                input logic        ovf,
                                                input logic [15:0] len);
        logic [63:0] h;
        h = '0;
        h[HDR_MAGIC_LSB +: 16] = HDR_MAGIC;
        h[HDR_SEQ_LSB +: 8]    = seq;
        h[HDR_OVF_BIT]         = ovf;
        h[HDR_LEN_LSB +: 16]   = len;
        return h;
    endfunction

endpackage

// File: rtl/encode_pack_fifo.sv
// Synchronous first-word-fall-through FIFO with registered occupancy count.
// A write while full is accepted when a read happens in the same cycle.
module encode_pack_fifo #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 256
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int             AW      = $clog2(DEPTH);
    localparam logic [AW:0]    DEPTH_C = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              wr_ok;
    logic              rd_ok;

    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign rd_ok   = rd_en && !empty;
    assign wr_ok   = wr_en && (!full || rd_ok);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/encode_packer.sv
// Captures decimated encoder samples into a FIFO and emits them as framed
// 64-bit packets (header word followed by samples) on a valid/ready stream.
module encode_packer
    import encode_pack_pkg::*;
#(
    parameter int ENCODE_WID = 32,
    parameter int PKT_LEN    = 64,
    parameter int FIFO_DEPTH = 256,
    parameter int SYNC_ZERO  = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  stop_i,
    input  logic [15:0]           decim_i,
    input  logic                  precise_encode_en_i,
    input  logic [ENCODE_WID-1:0] precise_encode_w_i,
    input  logic [ENCODE_WID-1:0] precise_encode_x_i,
    input  logic                  wafer_zero_flag_i,
    output logic [63:0]           m_data_o,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic                  m_last_o,
    output logic                  busy_o,
    output logic                  overflow_o,
    output logic [15:0]           drop_cnt_o
);
    localparam int          CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [31:0] PKT_LEN_U = 32'(PKT_LEN);

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    cap_state_t cap_state, cap_next;
    out_state_t out_state, out_next;

    logic              zero_q;
    logic              zero_rise;
    logic              enter_run;
    logic              window;
    logic              keep;
    logic              flush_pend;
    logic [15:0]       decim_q;
    logic [15:0]       decim_in_eff;
    logic [15:0]       decim_eff;
    logic [15:0]       dec_cnt;
    logic [15:0]       cnt_now;

    logic              wr_vld_p1;
    logic [63:0]       wr_data_p1;
    logic              drop;

    logic              fifo_rd_en;
    logic [63:0]       fifo_rd_data;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;

    logic [15:0]       pkt_len;
    logic [15:0]       pkt_len_next;
    logic [15:0]       words_left;
    logic [7:0]        seq;
    logic              hdr_ovf;

    assign zero_rise = wafer_zero_flag_i && !zero_q;

    always_comb begin
        cap_next = cap_state;
        case (cap_state)
            CAP_IDLE:
                if (!stop_i && start_i)
                    cap_next = (SYNC_ZERO != 0) ? CAP_WAIT_ZERO : CAP_RUN;
            CAP_WAIT_ZERO:
                if (stop_i)         cap_next = CAP_IDLE;
                else if (zero_rise) cap_next = CAP_RUN;
            CAP_RUN:
                if (stop_i)         cap_next = CAP_IDLE;
            default:                cap_next = CAP_IDLE;
        endcase
    end

    // The cycle that enters RUN already captures, so a sample coincident with
    // the zero edge is the first one kept. The stop cycle itself captures nothing.
    assign enter_run    = (cap_next == CAP_RUN) && (cap_state != CAP_RUN);
    assign window       = ((cap_state == CAP_RUN) && !stop_i) || enter_run;
    assign decim_in_eff = (decim_i == 16'd0) ? 16'd1 : decim_i;
    assign decim_eff    = enter_run ? decim_in_eff : decim_q;
    assign cnt_now      = enter_run ? 16'd0 : dec_cnt;
    assign keep         = precise_encode_en_i && window && (cnt_now == 16'd0);

    assign drop = wr_vld_p1 && fifo_full && !fifo_rd_en;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cap_state  <= CAP_IDLE;
            zero_q     <= 1'b0;
            decim_q    <= 16'd1;
            dec_cnt    <= 16'd0;
            flush_pend <= 1'b0;
            wr_vld_p1  <= 1'b0;
            overflow_o <= 1'b0;
            drop_cnt_o <= 16'd0;
        end else begin
            cap_state <= cap_next;
            zero_q    <= wafer_zero_flag_i;
            if (enter_run) decim_q <= decim_in_eff;
            if (window) begin
                if (precise_encode_en_i)
                    dec_cnt <= (cnt_now == decim_eff - 16'd1) ? 16'd0 : cnt_now + 16'd1;
                else
                    dec_cnt <= cnt_now;
            end
            wr_vld_p1 <= keep;
            if ((cap_state == CAP_RUN) && stop_i)
                flush_pend <= 1'b1;
            else if (flush_pend && (out_state == O_IDLE) && (fifo_count == '0) && !wr_vld_p1)
                flush_pend <= 1'b0;
            if (drop) begin
                overflow_o <= 1'b1;
                drop_cnt_o <= sat_inc16(drop_cnt_o);
            end
        end
    end

    // Stage p1: kept sample registered, written into the FIFO on the next edge.
    always_ff @(posedge clk_i) begin
        wr_data_p1 <= pack_sample(precise_encode_w_i, precise_encode_x_i);
    end

    encode_pack_fifo #(
        .DATA_W (SAMPLE_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk_i),
        .rst     (rst_i),
        .wr_en   (wr_vld_p1),
        .wr_data (wr_data_p1),
        .rd_en   (fifo_rd_en),
        .rd_data (fifo_rd_data),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // The header's overflow bit is frozen when the packet is committed so the
    // word cannot change while the sink is stalling.
    always_comb begin
        out_next     = out_state;
        pkt_len_next = pkt_len;
        m_valid_o    = 1'b0;
        m_last_o     = 1'b0;
        m_data_o     = '0;
        fifo_rd_en   = 1'b0;
        case (out_state)
            O_IDLE: begin
                if (32'(fifo_count) >= PKT_LEN_U) begin
                    out_next     = O_HDR;
                    pkt_len_next = 16'(PKT_LEN);
                end else if (flush_pend && (fifo_count != '0)) begin
                    out_next     = O_HDR;
                    pkt_len_next = 16'(fifo_count);
                end
            end
            O_HDR: begin
                m_valid_o = 1'b1;
                m_data_o  = make_header(seq, hdr_ovf, pkt_len);
                if (m_ready_i) out_next = O_DATA;
            end
            O_DATA: begin
                m_valid_o  = 1'b1;
                m_data_o   = fifo_rd_data;
                m_last_o   = (words_left == 16'd1);
                fifo_rd_en = m_ready_i && !fifo_empty;
                if (m_ready_i && (words_left == 16'd1)) out_next = O_IDLE;
            end
            default: out_next = O_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_state  <= O_IDLE;
            pkt_len    <= 16'd0;
            words_left <= 16'd0;
            seq        <= 8'd0;
            hdr_ovf    <= 1'b0;
        end else begin
            out_state <= out_next;
            if ((out_state == O_IDLE) && (out_next == O_HDR)) begin
                pkt_len <= pkt_len_next;
                hdr_ovf <= overflow_o;
            end
            if ((out_state == O_HDR) && m_ready_i)
                words_left <= pkt_len;
            else if ((out_state == O_DATA) && m_ready_i)
                words_left <= words_left - 16'd1;
            if ((out_state == O_DATA) && m_ready_i && (words_left == 16'd1))
                seq <= seq + 8'd1;
        end
    end

    assign busy_o = (cap_state != CAP_IDLE) || (out_state != O_IDLE) || flush_pend;

endmodule

// File: tb/tb_encode_packer.sv
// Directed bench for encode_packer: one instance free-running (SYNC_ZERO=0) and
// one zero-aligned (SYNC_ZERO=1), both with PKT_LEN=4 and an 8-deep FIFO.
module tb_encode_packer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start [2];
    logic        stop  [2];
    logic        en    [2];
    logic        zf    [2];
    logic        rdy   [2];
    logic [15:0] decim [2];
    logic [31:0] pw    [2];
    logic [31:0] px    [2];
    logic [63:0] m_data  [2];
    logic        m_valid [2];
    logic        m_last  [2];
    logic        busy    [2];
    logic        ovf     [2];
    logic [15:0] dcnt    [2];

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_seq [2];

    always #5 clk = ~clk;

    encode_packer #(.ENCODE_WID(32), .PKT_LEN(4), .FIFO_DEPTH(8), .SYNC_ZERO(0)) dut0 (
        .clk_i(clk), .rst_i(rst), .start_i(start[0]), .stop_i(stop[0]), .decim_i(decim[0]),
        .precise_encode_en_i(en[0]), .precise_encode_w_i(pw[0]), .precise_encode_x_i(px[0]),
        .wafer_zero_flag_i(zf[0]), .m_data_o(m_data[0]), .m_valid_o(m_valid[0]),
        .m_ready_i(rdy[0]), .m_last_o(m_last[0]), .busy_o(busy[0]),
        .overflow_o(ovf[0]), .drop_cnt_o(dcnt[0]));

    encode_packer #(.ENCODE_WID(32), .PKT_LEN(4), .FIFO_DEPTH(8), .SYNC_ZERO(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .start_i(start[1]), .stop_i(stop[1]), .decim_i(decim[1]),
        .precise_encode_en_i(en[1]), .precise_encode_w_i(pw[1]), .precise_encode_x_i(px[1]),
        .wafer_zero_flag_i(zf[1]), .m_data_o(m_data[1]), .m_valid_o(m_valid[1]),
        .m_ready_i(rdy[1]), .m_last_o(m_last[1]), .busy_o(busy[1]),
        .overflow_o(ovf[1]), .drop_cnt_o(dcnt[1]));

    function automatic logic [63:0] hdr(input logic [7:0] s, input logic o, input logic [15:0] l);
        return {16'hEC0D, s, 7'd0, o, l, 16'h0000};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic arm(input int d, input logic [15:0] dv);
        @(negedge clk);
        rdy[d] = 1'b0; decim[d] = dv; start[d] = 1'b1;
        @(negedge clk);
        start[d] = 1'b0;
    endtask

    task automatic push(input int d, input logic [31:0] w, input logic [31:0] x);
        @(negedge clk);
        en[d] = 1'b1; pw[d] = w; px[d] = x;
    endtask

    task automatic end_capture(input int d);
        @(negedge clk);
        en[d] = 1'b0; stop[d] = 1'b1;
        @(negedge clk);
        stop[d] = 1'b0;
    endtask

    task automatic recv(input int d, input logic [63:0] exp, input logic exp_last,
                        input string nm, input bit rnd);
        bit         held;
        bit         done;
        logic [63:0] hd;
        logic        hl;
        held = 1'b0; done = 1'b0; hd = '0; hl = 1'b0;
        for (int n = 0; n < 400 && !done; n++) begin
            @(negedge clk);
            if (held) begin
                chk({nm, "_hold_valid"}, 64'(m_valid[d]), 64'd1);
                chk({nm, "_hold_data"}, m_data[d], hd);
                chk({nm, "_hold_last"}, 64'(m_last[d]), 64'(hl));
            end
            held = 1'b0;
            rdy[d] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (m_valid[d] && rdy[d]) begin
                chk(nm, m_data[d], exp);
                chk({nm, "_last"}, 64'(m_last[d]), 64'(exp_last));
                done = 1'b1;
            end else if (m_valid[d]) begin
                held = 1'b1; hd = m_data[d]; hl = m_last[d];
            end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL %s timeout: no valid word, expected %h", nm, exp);
        end
    endtask

    task automatic recv_hdr(input int d, input logic o, input logic [15:0] l,
                            input string nm, input bit rnd);
        recv(d, hdr(exp_seq[d], o, l), 1'b0, nm, rnd);
        exp_seq[d] = exp_seq[d] + 8'd1;
    endtask

    task automatic wait_quiet(input int d, input string nm);
        int n;
        n = 0;
        @(negedge clk);
        while (busy[d] && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk({nm, "_busy"}, 64'(busy[d]), 64'd0);
        chk({nm, "_valid"}, 64'(m_valid[d]), 64'd0);
    endtask

    typedef struct {
        logic [31:0] w;
        logic [31:0] x;
        logic [63:0] exp;
    } smp_vec_t;

    typedef struct {
        logic [15:0]      decim;
        int               nsamp;
        logic [31:0]      base;
        logic [15:0]      len;
        logic [3:0][31:0] ew;
    } dec_vec_t;

    smp_vec_t sv [8];
    dec_vec_t dv [4];

    initial begin
        sv[0] = '{32'd0, 32'd512, 64'h0000_0000_0000_0200};
        sv[1] = '{32'd1, 32'd513, 64'h0000_0001_0000_0201};
        sv[2] = '{32'd2, 32'd514, 64'h0000_0002_0000_0202};
        sv[3] = '{32'd3, 32'd515, 64'h0000_0003_0000_0203};
        sv[4] = '{32'd4, 32'd516, 64'h0000_0004_0000_0204};
        sv[5] = '{32'd5, 32'd517, 64'h0000_0005_0000_0205};
        sv[6] = '{32'd6, 32'd518, 64'h0000_0006_0000_0206};
        sv[7] = '{32'd7, 32'd519, 64'h0000_0007_0000_0207};
        dv[0] = '{16'd3, 9, 32'd1000, 16'd3, {32'd0,    32'd1006, 32'd1003, 32'd1000}};
        dv[1] = '{16'd0, 3, 32'd1100, 16'd3, {32'd0,    32'd1102, 32'd1101, 32'd1100}};
        dv[2] = '{16'd1, 2, 32'd1200, 16'd2, {32'd0,    32'd0,    32'd1201, 32'd1200}};
        dv[3] = '{16'd2, 7, 32'd1300, 16'd4, {32'd1306, 32'd1304, 32'd1302, 32'd1300}};

        for (int d = 0; d < 2; d++) begin
            start[d] = 0; stop[d] = 0; en[d] = 0; zf[d] = 0; rdy[d] = 0;
            decim[d] = 16'd1; pw[d] = '0; px[d] = '0; exp_seq[d] = 8'd0;
        end

        // Reset state
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_valid", 64'(m_valid[d]), 64'd0);
            chk("rst_data", m_data[d], 64'd0);
            chk("rst_busy", 64'(busy[d]), 64'd0);
            chk("rst_ovf", 64'(ovf[d]), 64'd0);
            chk("rst_drop", 64'(dcnt[d]), 64'd0);
        end
        rst = 1'b0;

        // Two full packets from eight consecutive samples
        arm(0, 16'd1);
        for (int i = 0; i < 8; i++) push(0, sv[i].w, sv[i].x);
        end_capture(0);
        for (int p = 0; p < 2; p++) begin
            recv_hdr(0, 1'b0, 16'd4, "t1_hdr", 1'b0);
            for (int k = 0; k < 4; k++)
                recv(0, sv[p*4+k].exp, (k == 3), "t1_data", 1'b0);
        end
        wait_quiet(0, "t1_end");

        // Decimation table, each run closed by stop
        for (int i = 0; i < 4; i++) begin
            arm(0, dv[i].decim);
            for (int s = 0; s < dv[i].nsamp; s++)
                push(0, dv[i].base + 32'(s), dv[i].base + 32'(s) + 32'd512);
            end_capture(0);
            recv_hdr(0, 1'b0, dv[i].len, "t2_hdr", 1'b0);
            for (int k = 0; k < 32'(dv[i].len); k++)
                recv(0, {dv[i].ew[k], dv[i].ew[k] + 32'd512}, (k == 32'(dv[i].len) - 1),
                     "t2_data", 1'b0);
            wait_quiet(0, "t2_end");
        end

        // Zero-aligned capture: pre-edge samples ignored, edge sample kept
        arm(1, 16'd1);
        for (int s = 0; s < 3; s++) push(1, 32'd100 + 32'(s), 32'd612 + 32'(s));
        @(negedge clk);
        zf[1] = 1'b1; en[1] = 1'b1; pw[1] = 32'd200; px[1] = 32'd712;
        for (int s = 1; s < 4; s++) push(1, 32'd200 + 32'(s), 32'd712 + 32'(s));
        end_capture(1);
        zf[1] = 1'b0;
        recv_hdr(1, 1'b0, 16'd4, "t3_hdr", 1'b0);
        for (int k = 0; k < 4; k++)
            recv(1, {32'd200 + 32'(k), 32'd712 + 32'(k)}, (k == 3), "t3_data", 1'b0);
        wait_quiet(1, "t3_end");

        // Stop while waiting for the zero mark emits nothing
        arm(1, 16'd1);
        @(negedge clk);
        chk("t3_wait_busy", 64'(busy[1]), 64'd1);
        push(1, 32'd300, 32'd812);
        push(1, 32'd301, 32'd813);
        end_capture(1);
        wait_quiet(1, "t3_stop_wait");
        rdy[1] = 1'b1;
        repeat (5) @(negedge clk);
        chk("t3_no_output", 64'(m_valid[1]), 64'd0);
        rdy[1] = 1'b0;

        // Stop after six samples: full packet then short flush packet
        arm(0, 16'd1);
        for (int s = 0; s < 6; s++) push(0, 32'd400 + 32'(s), 32'd912 + 32'(s));
        end_capture(0);
        recv_hdr(0, 1'b0, 16'd4, "t4_hdr_full", 1'b0);
        for (int k = 0; k < 4; k++)
            recv(0, {32'd400 + 32'(k), 32'd912 + 32'(k)}, (k == 3), "t4_data", 1'b0);
        recv_hdr(0, 1'b0, 16'd2, "t4_hdr_short", 1'b0);
        for (int k = 4; k < 6; k++)
            recv(0, {32'd400 + 32'(k), 32'd912 + 32'(k)}, (k == 5), "t4_data_short", 1'b0);
        wait_quiet(0, "t4_end");

        // Overflow with sink stalled, then drain under random back-pressure
        arm(0, 16'd1);
        for (int s = 0; s < 12; s++) push(0, 32'd500 + 32'(s), 32'd1012 + 32'(s));
        end_capture(0);
        repeat (2) @(negedge clk);
        chk("t5_overflow", 64'(ovf[0]), 64'd1);
        chk("t5_drop_cnt", 64'(dcnt[0]), 64'd4);
        recv_hdr(0, 1'b0, 16'd4, "t5_hdr0", 1'b1);
        for (int k = 0; k < 4; k++)
            recv(0, {32'd500 + 32'(k), 32'd1012 + 32'(k)}, (k == 3), "t5_data0", 1'b1);
        recv_hdr(0, 1'b1, 16'd4, "t5_hdr1", 1'b1);
        for (int k = 4; k < 8; k++)
            recv(0, {32'd500 + 32'(k), 32'd1012 + 32'(k)}, (k == 7), "t5_data1", 1'b1);
        wait_quiet(0, "t5_end");
        chk("t5_drop_hold", 64'(dcnt[0]), 64'd4);

        // Asynchronous reset in the middle of a packet
        arm(0, 16'd1);
        for (int s = 0; s < 4; s++) push(0, 32'd600 + 32'(s), 32'd1112 + 32'(s));
        @(negedge clk);
        en[0] = 1'b0;
        recv_hdr(0, 1'b1, 16'd4, "t6_hdr", 1'b0);
        @(negedge clk);
        rdy[0] = 1'b0;
        chk("t6_in_data_valid", 64'(m_valid[0]), 64'd1);
        chk("t6_in_data_word", m_data[0], {32'd600, 32'd1112});
        rst = 1'b1;
        #1;
        chk("t6_rst_valid", 64'(m_valid[0]), 64'd0);
        chk("t6_rst_last", 64'(m_last[0]), 64'd0);
        chk("t6_rst_data", m_data[0], 64'd0);
        chk("t6_rst_busy", 64'(busy[0]), 64'd0);
        chk("t6_rst_ovf", 64'(ovf[0]), 64'd0);
        chk("t6_rst_drop", 64'(dcnt[0]), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_seq[0] = 8'd0;
        exp_seq[1] = 8'd0;
        arm(0, 16'd1);
        for (int s = 0; s < 4; s++) push(0, 32'd700 + 32'(s), 32'd1212 + 32'(s));
        end_capture(0);
        recv_hdr(0, 1'b0, 16'd4, "t6_hdr_after", 1'b0);
        for (int k = 0; k < 4; k++)
            recv(0, {32'd700 + 32'(k), 32'd1212 + 32'(k)}, (k == 3), "t6_data_after", 1'b0);
        wait_quiet(0, "t6_end");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
